photodiode_event_scanner: RTL

//  Parametrised successor to the fixed 8-input photodiode_0 harp-beam reader. Samples NUM_CH beam photodiodes,

---
 rtl/pd_scan_pkg.sv | 25 ++
 rtl/pd_debounce.sv | 47 ++++
 rtl/photodiode_event_scanner.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pd_scan_pkg.sv
// Shared register map, CTRL/STATUS bit positions and event layout for the
// photodiode event scanner.
package pd_scan_pkg;
  localparam logic [1:0] ADDR_LEVEL  = 2'd0;
  localparam logic [1:0] ADDR_EVENT  = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_IRQ_EN  = 16;
  localparam int CTRL_RISE_EN = 17;
  localparam int CTRL_FALL_EN = 18;

  localparam int STAT_OVF   = 16;
  localparam int STAT_EMPTY = 17;

  localparam int EV_CH_W = 6;
  localparam int EV_TS_W = 24;

  // Packs to the EVENT word below the valid bit: [30]=brk [29:24]=ch [23:0]=ts
  typedef struct packed {
    logic               brk;
    logic [EV_CH_W-1:0] ch;
    logic [EV_TS_W-1:0] ts;
  } ev_t;
endpackage

// File: rtl/pd_debounce.sv
// One photodiode channel: 2-FF synchroniser, polarity fix-up, stability counter
// and single-cycle break/restore strobes coincident with the level flip.
module pd_debounce #(
  parameter int DEBOUNCE_CYC = 1000,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_pd,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  localparam int CW = $clog2(DEBOUNCE_CYC);

  logic          r_s1, r_s2, r_level;
  logic [CW-1:0] r_cnt;
  logic          w_sync, w_flip;

  assign w_sync = r_s2 ^ ACTIVE_LOW;
  // Flip on the DEBOUNCE_CYC-th consecutive mismatching cycle.
  assign w_flip = (w_sync != r_level) && (r_cnt == CW'(DEBOUNCE_CYC - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1    <= ACTIVE_LOW;
      r_s2    <= ACTIVE_LOW;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1 <= i_pd;
      r_s2 <= r_s1;
      if (w_sync == r_level) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_cnt   <= '0;
        r_level <= w_sync;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = w_flip & w_sync;
  assign o_fall  = w_flip & ~w_sync;
endmodule

// File: rtl/photodiode_event_scanner.sv
// Multi-channel beam-break scanner: debounced levels, timestamped edge events
// queued in a FIFO, drained over an Avalon-MM slave with a level IRQ.
module photodiode_event_scanner
  import pd_scan_pkg::*;
#(
  parameter int NUM_CH       = 8,
  parameter int DEBOUNCE_CYC = 1000,
  parameter int FIFO_DEPTH   = 16,
  parameter int TS_WIDTH     = 24,
  parameter int TS_PRESCALE  = 50,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] pd_in,
  input  logic [1:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = (TS_PRESCALE > 1) ? $clog2(TS_PRESCALE) : 1;

  logic [NUM_CH-1:0]   w_level, w_rise, w_fall, w_qual, w_grant;
  logic [NUM_CH-1:0]   r_pending, r_pend_edge, w_pend_nxt, w_pedge_nxt;
  logic [NUM_CH-1:0]   r_mask;
  logic                r_irq_en, r_rise_en, r_fall_en, r_ovf, r_irq;
  logic [PW-1:0]       r_pre;
  logic [TS_WIDTH-1:0] r_ts;
  logic [AW:0]         r_wptr, r_rptr, w_count;
  ev_t                 r_mem [FIFO_DEPTH];
  ev_t                 w_ev, w_head;
  logic [EV_CH_W-1:0]  w_sel;
  logic                w_sel_edge, w_push, w_pop, w_wen, w_drop, w_ovf_pend;
  logic                w_empty, w_full, w_wr_ctrl, w_wr_stat;
  logic [31:0]         w_ctrl, w_rd, r_rdata;
  logic                w_unused_wd;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pd_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .ACTIVE_LOW(ACTIVE_LOW)) u_db (
      .clk(clk), .reset_n(reset_n), .i_pd(pd_in[g]),
      .o_level(w_level[g]), .o_rise(w_rise[g]), .o_fall(w_fall[g])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre <= '0;
      r_ts  <= '0;
    end else if (r_pre == PW'(TS_PRESCALE - 1)) begin
      r_pre <= '0;
      r_ts  <= r_ts + TS_WIDTH'(1);
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  assign w_wr_ctrl = avs_write && (avs_address == ADDR_CTRL);
  assign w_wr_stat = avs_write && (avs_address == ADDR_STATUS);
  assign w_qual    = r_mask & ((w_rise & {NUM_CH{r_rise_en}}) | (w_fall & {NUM_CH{r_fall_en}}));
  assign w_grant   = r_pending & (~r_pending + NUM_CH'(1));
  assign w_push    = |r_pending;

  always_comb begin
    w_sel      = '0;
    w_sel_edge = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_sel      = EV_CH_W'(i);
        w_sel_edge = r_pend_edge[i];
      end
    end
  end

  // A new edge may re-arm a channel in the same cycle its old event is granted.
  always_comb begin
    w_pend_nxt  = r_pending & ~w_grant;
    w_pedge_nxt = r_pend_edge;
    w_ovf_pend  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_qual[i]) begin
        if (w_pend_nxt[i]) begin
          w_ovf_pend = 1'b1;
        end else begin
          w_pend_nxt[i]  = 1'b1;
          w_pedge_nxt[i] = w_rise[i];
        end
      end
    end
    if (w_wr_ctrl) w_pend_nxt = w_pend_nxt & avs_writedata[NUM_CH-1:0];
  end

  assign w_ev    = '{brk: w_sel_edge, ch: w_sel, ts: EV_TS_W'(r_ts)};
  assign w_count = r_wptr - r_rptr;
  assign w_empty = (w_count == '0);
  assign w_full  = (w_count == (AW+1)'(FIFO_DEPTH));
  assign w_pop   = avs_read && (avs_address == ADDR_EVENT) && !w_empty;
  assign w_wen   = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;
  assign w_head  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_wen) r_mem[r_wptr[AW-1:0]] <= w_ev;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending   <= '0;
      r_pend_edge <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_ovf       <= 1'b0;
      r_mask      <= '1;
      r_irq_en    <= 1'b0;
      r_rise_en   <= 1'b1;
      r_fall_en   <= 1'b1;
      r_rdata     <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_pending   <= w_pend_nxt;
      r_pend_edge <= w_pedge_nxt;
      if (w_wen) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop) r_rptr <= r_rptr + (AW+1)'(1);
      if (w_drop || w_ovf_pend)               r_ovf <= 1'b1;
      else if (w_wr_stat && avs_writedata[STAT_OVF]) r_ovf <= 1'b0;
      if (w_wr_ctrl) begin
        r_mask    <= avs_writedata[NUM_CH-1:0];
        r_irq_en  <= avs_writedata[CTRL_IRQ_EN];
        r_rise_en <= avs_writedata[CTRL_RISE_EN];
        r_fall_en <= avs_writedata[CTRL_FALL_EN];
      end
      r_rdata <= avs_read ? w_rd : '0;
      r_irq   <= r_irq_en & ~w_empty;
    end
  end

  always_comb begin
    w_ctrl               = 32'(r_mask);
    w_ctrl[CTRL_IRQ_EN]  = r_irq_en;
    w_ctrl[CTRL_RISE_EN] = r_rise_en;
    w_ctrl[CTRL_FALL_EN] = r_fall_en;
    w_rd                 = '0;
    case (avs_address)
      ADDR_LEVEL: w_rd = 32'(w_level);
      ADDR_EVENT: w_rd = w_empty ? '0 : {1'b1, w_head};
      ADDR_CTRL:  w_rd = w_ctrl;
      default: begin
        w_rd             = 32'(w_count);
        w_rd[STAT_OVF]   = r_ovf;
        w_rd[STAT_EMPTY] = w_empty;
      end
    endcase
  end

  assign w_unused_wd  = ^avs_writedata;
  assign avs_readdata = r_rdata;
  assign irq          = r_irq;
endmodule
